// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment serial display driver.
// Glyph table holds segments {g,f,e,d,c,b,a} for nibble values 0-F.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH
  } state_t;

  localparam int SEG_BITS = 8;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational nibble-to-segment encoder; output byte is {dp,g,f,e,d,c,b,a}.
// A blanked digit drops its segments but keeps its decimal point.
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0]          nibble,
  input  logic                dp,
  input  logic                blank,
  output logic [SEG_BITS-1:0] seg
);

  assign seg = {dp, blank ? 7'h00 : GLYPH[nibble]};

endmodule

// File: rtl/display_serializer.sv
// Serialises DIGITS encoded 7-segment bytes onto data_out/data_clk, then pulses latch.
// Frame: 1 LOAD cycle, 2*CLK_DIV cycles per bit, CLK_DIV latch cycles; start while busy is dropped.
module display_serializer
  import display_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 2,
  parameter int LSB_FIRST      = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int REFRESH_GAP    = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                auto_mode,
  input  logic                start,
  input  logic                blank_lz,
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic [DIGITS-1:0]   dp_in,
  output logic                data_out,
  output logic                data_clk,
  output logic                latch,
  output logic                sending_data,
  output logic                busy,
  output logic                done
);

  localparam int TOTAL = SEG_BITS * DIGITS;
  localparam int CNT_W = $clog2(TOTAL);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = $clog2(REFRESH_GAP + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REFRESH_GAP - 1);

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DIV_W-1:0]    div;
  logic [GAP_W-1:0]    gap;
  logic [TOTAL-1:0]    frame;

  logic [DIGITS-1:0]   blank;
  logic [SEG_BITS-1:0] seg_raw [DIGITS];
  logic [TOTAL-1:0]    ser;

  // Blanking runs from the top digit down and stops at the first nonzero digit.
  always_comb begin
    logic lead;
    lead  = blank_lz;
    blank = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (d != 0 && lead && bcd_in[4*d +: 4] == 4'h0) begin
        blank[d] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_to_seg u_seg (
      .nibble (bcd_in[4*g +: 4]),
      .dp     (dp_in[g]),
      .blank  (blank[g]),
      .seg    (seg_raw[g])
    );
  end

  // ser is laid out in transmit order: ser[TOTAL-1] goes out first.
  always_comb begin
    logic [SEG_BITS-1:0] byte_v;
    ser    = '0;
    byte_v = '0;
    for (int d = 0; d < DIGITS; d++) begin
      byte_v = seg_raw[d] ^ {SEG_BITS{SEG_ACTIVE_LOW != 0}};
      for (int b = 0; b < SEG_BITS; b++) begin
        ser[SEG_BITS*d + b] = (LSB_FIRST != 0) ? byte_v[SEG_BITS-1-b] : byte_v[b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      div          <= '0;
      gap          <= '0;
      frame        <= '0;
      data_out     <= 1'b0;
      data_clk     <= 1'b0;
      latch        <= 1'b0;
      sending_data <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && (start || (auto_mode && gap == GAP_LAST))) begin
            state        <= ST_LOAD;
            busy         <= 1'b1;
            sending_data <= 1'b1;
            gap          <= '0;
          end else if (gap != GAP_LAST) begin
            gap <= gap + GAP_W'(1);
          end
        end

        ST_LOAD: begin
          frame    <= ser;
          bit_cnt  <= CNT_LAST;
          data_out <= ser[TOTAL-1];
          data_clk <= 1'b0;
          div      <= '0;
          state    <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (div == DIV_LAST) begin
            div <= '0;
            if (!data_clk) begin
              data_clk <= 1'b1;
            end else if (bit_cnt == '0) begin
              data_clk     <= 1'b0;
              data_out     <= 1'b0;
              sending_data <= 1'b0;
              latch        <= 1'b1;
              state        <= ST_LATCH;
            end else begin
              data_clk <= 1'b0;
              bit_cnt  <= bit_cnt - CNT_W'(1);
              data_out <= frame[bit_cnt - CNT_W'(1)];
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        ST_LATCH: begin
          if (div == DIV_LAST) begin
            div   <= '0;
            latch <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_serializer.sv
// Directed bench: dut0 is MSB-first active-high, dut1 is LSB-first active-low, both on shared inputs.
module tb_display_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        auto_mode = 1'b0;
  logic        start = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;

  logic do0, dc0, lat0, sd0, busy0, done0;
  logic do1, dc1, lat1, sd1, busy1, done1;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap0, cap1;
  int cap_nb, cap_lat, cap_done, cap_sd, cap_busy;

  int          mid_at = -1;
  logic [15:0] mid_bcd = 16'h0000;
  logic        mid_en = 1'b1;
  logic        mid_start = 1'b0;

  int n;

  always #5 clk = ~clk;

  display_serializer #(
    .DIGITS(4), .CLK_DIV(2), .LSB_FIRST(0), .SEG_ACTIVE_LOW(0), .REFRESH_GAP(8)
  ) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .auto_mode(auto_mode), .start(start),
    .blank_lz(blank_lz), .bcd_in(bcd_in), .dp_in(dp_in),
    .data_out(do0), .data_clk(dc0), .latch(lat0), .sending_data(sd0),
    .busy(busy0), .done(done0)
  );

  display_serializer #(
    .DIGITS(4), .CLK_DIV(2), .LSB_FIRST(1), .SEG_ACTIVE_LOW(1), .REFRESH_GAP(8)
  ) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .auto_mode(auto_mode), .start(start),
    .blank_lz(blank_lz), .bcd_in(bcd_in), .dp_in(dp_in),
    .data_out(do1), .data_clk(dc1), .latch(lat1), .sending_data(sd1),
    .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Follows one frame to its done pulse; cycle 0 is the LOAD cycle when do_start is set.
  task automatic capture(input bit do_start);
    logic p0, p1;
    cap0 = '0; cap1 = '0;
    cap_nb = 0; cap_lat = 0; cap_done = -1; cap_sd = 0; cap_busy = 0;
    p0 = dc0; p1 = dc1;
    if (do_start) start = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (dc0 && !p0) begin cap0 = {cap0[30:0], do0}; cap_nb++; end
      if (dc1 && !p1) cap1 = {cap1[30:0], do1};
      p0 = dc0; p1 = dc1;
      if (lat0)  cap_lat++;
      if (sd0)   cap_sd++;
      if (busy0) cap_busy++;
      if (c == mid_at) begin
        bcd_in = mid_bcd; enable = mid_en; start = mid_start;
      end else if (c == mid_at + 1) begin
        start = 1'b0;
      end
      if (done0) begin cap_done = c; break; end
    end
  endtask

  task automatic count_idle(output int cnt);
    cnt = -1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (busy0) begin cnt = c; break; end
    end
  endtask

  task automatic busy_cycles(input int len, output int cnt);
    cnt = 0;
    repeat (len) begin
      @(negedge clk);
      if (busy0 || busy1) cnt++;
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs0", {26'd0, do0, dc0, lat0, sd0, busy0, done0}, 32'd0);
    chk("reset_outputs1", {26'd0, do1, dc1, lat1, sd1, busy1, done1}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    enable = 1'b1; bcd_in = 16'h8888; dp_in = 4'h0; blank_lz = 1'b0;
    capture(1);
    chk("8888_bits", cap0, 32'h7F7F7F7F);
    chk("8888_bits_lsb_inv", cap1, 32'h01010101);
    chk("8888_nbits", cap_nb, 32);
    chk("8888_latch_cycles", cap_lat, 2);
    chk("8888_done_cycle", cap_done, 131);
    chk("8888_sending_cycles", cap_sd, 129);
    chk("8888_busy_cycles", cap_busy, 131);

    bcd_in = 16'h0012; blank_lz = 1'b1; dp_in = 4'b0100;
    capture(1);
    chk("0012_blank", cap0, 32'h0080065B);
    chk("0012_blank_lsb_inv", cap1, 32'hFFFE9F25);
    blank_lz = 1'b0;
    capture(1);
    chk("0012_noblank", cap0, 32'h3FBF065B);

    bcd_in = 16'h000F; dp_in = 4'h0;
    capture(1);
    chk("000F_noblank", cap0, 32'h3F3F3F71);
    chk("000F_noblank_lsb_inv", cap1, 32'h03030371);
    blank_lz = 1'b1;
    capture(1);
    chk("000F_blank", cap0, 32'h00000071);
    chk("000F_blank_lsb_inv", cap1, 32'hFFFFFF71);
    blank_lz = 1'b0;

    // Start pulse and input change during SHIFT.
    bcd_in = 16'h8888;
    mid_at = 40; mid_bcd = 16'h1234; mid_en = 1'b1; mid_start = 1'b1;
    capture(1);
    chk("busy_start_frame", cap0, 32'h7F7F7F7F);
    chk("busy_start_done", cap_done, 131);
    busy_cycles(50, n);
    chk("busy_start_dropped", n, 0);

    // Enable falls mid-frame.
    mid_at = 30; mid_bcd = 16'h1234; mid_en = 1'b0; mid_start = 1'b0;
    capture(1);
    chk("en_drop_frame", cap0, 32'h065B4F66);
    chk("en_drop_done", cap_done, 131);
    mid_at = -1;
    auto_mode = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cycles(50, n);
    chk("en_low_stays_idle", n, 0);

    // Auto refresh; start coincides with the first auto trigger.
    enable = 1'b1;
    capture(1);
    chk("auto_first_frame", cap0, 32'h065B4F66);
    chk("auto_start_single", cap_done, 131);
    count_idle(n);
    chk("auto_gap1", n, 8);
    mid_at = 10; mid_bcd = 16'h5678; mid_en = 1'b1; mid_start = 1'b0;
    capture(0);
    chk("auto_inflight_frame", cap0, 32'h065B4F66);
    mid_at = -1;
    count_idle(n);
    chk("auto_gap2", n, 8);
    auto_mode = 1'b0;
    capture(0);
    chk("auto_next_frame", cap0, 32'h6D7D077F);
    busy_cycles(40, n);
    chk("auto_off_idle", n, 0);

    // Reset asserted during bit 10.
    bcd_in = 16'h8888;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (41) @(negedge clk);
    chk("midframe_sending", {31'd0, sd0}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midreset_outputs0", {26'd0, do0, dc0, lat0, sd0, busy0, done0}, 32'd0);
    chk("midreset_outputs1", {26'd0, do1, dc1, lat1, sd1, busy1, done1}, 32'd0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (lat0 || lat1) n++;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (lat0 || lat1 || busy0) n++;
    end
    chk("midreset_no_latch", n, 0);
    capture(1);
    chk("post_reset_frame", cap0, 32'h7F7F7F7F);
    chk("post_reset_nbits", cap_nb, 32);
    chk("post_reset_done", cap_done, 131);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
